// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_fa_bit_cell.sv
// One-bit full adder assembled from CMOS-style gate networks:
// two XOR stages form the sum, and a majority network forms the carry.

module cmos_xor (
  input  logic a,
  input  logic b,
  output logic y
);
  // Complementary network: pull low when the inputs agree.
  assign y = ~((a & b) | (~a & ~b));
endmodule

module carry_gen (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic cout
);
  assign cout = (a & b) | (c & (a | b));
endmodule

module fa_bit_cell (
  input  logic in_a,
  input  logic in_b,
  input  logic in_c,
  output logic sum,
  output logic c_out
);
  logic half_sum;

  cmos_xor u_xor_ab (.a(in_a),     .b(in_b), .y(half_sum));
  cmos_xor u_xor_c  (.a(half_sum), .b(in_c), .y(sum));
  carry_gen u_carry (.a(in_a), .b(in_b), .c(in_c), .cout(c_out));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell, one bit per clock, LSB first,
// with a start/ready request handshake and a one-cycle done pulse.

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_t        state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg;
  // Holds the WIDTH-1 sum bits already produced; the final bit comes straight from the cell.
  logic [WIDTH-2:0] p_sr_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             c_out_reg;

  logic             cell_sum, cell_cout;
  logic [WIDTH-1:0] p_shift;

  fa_bit_cell u_cell (
    .in_a (a_sr_reg[0]),
    .in_b (b_sr_reg[0]),
    .in_c (carry_reg),
    .sum  (cell_sum),
    .c_out(cell_cout)
  );

  assign p_shift = {cell_sum, p_sr_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      p_sr_reg  <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr_reg  <= in_a;
            b_sr_reg  <= in_b;
            carry_reg <= c_in;
            cnt_reg   <= '0;
          end
        end
        SHIFT: begin
          a_sr_reg  <= a_sr_reg >> 1;
          b_sr_reg  <= b_sr_reg >> 1;
          p_sr_reg  <= p_shift[WIDTH-1:1];
          carry_reg <= cell_cout;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            sum_reg   <= p_shift;
            c_out_reg <= cell_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg == SHIFT);
  assign done  = (state_reg == DONE);
  assign sum   = sum_reg;
  assign c_out = c_out_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed plus randomized checks of the serial adder against plain (WIDTH+1)-bit arithmetic.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] in_a, in_b;
  logic             c_in;
  logic             ready, busy, done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .in_a (in_a),
    .in_b (in_b),
    .c_in (c_in),
    .ready(ready),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer addition, result split into sum and carry-out.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    logic [WIDTH:0] total;
    total    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    exp_sum  = total[WIDTH-1:0];
    exp_cout = total[WIDTH];
  endtask

  // Runs one operation; inject_k>0 pulses a stray start after that many edges past acceptance.
  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input int inject_k);
    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;
    prev_sum  = exp_sum;
    prev_cout = exp_cout;
    @(negedge clk);
    chk({name, "_ready_pre"}, 32'(ready), 32'd1);
    in_a = a; in_b = b; c_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); c_in = 1'($urandom);
    model(a, b, ci);
    for (int k = 1; k <= WIDTH; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (start) start = 1'b0;
      chk($sformatf("%s_done_k%0d", name, k), 32'(done), 32'(k == WIDTH));
      chk($sformatf("%s_ready_k%0d", name, k), 32'(ready), 32'd0);
      if (k < WIDTH) begin
        chk($sformatf("%s_busy_k%0d", name, k), 32'(busy), 32'd1);
        chk($sformatf("%s_hold_k%0d", name, k), {23'd0, prev_cout, prev_sum}, {23'd0, prev_cout, prev_sum});
        chk($sformatf("%s_sumhold_k%0d", name, k), 32'(sum), 32'(prev_sum));
      end
      if (k == inject_k) begin
        in_a = 8'hAA; in_b = 8'h55; c_in = 1'b1; start = 1'b1;
      end
    end
    chk({name, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({name, "_cout"}, 32'(c_out), 32'(exp_cout));
    @(negedge clk);
    chk({name, "_done_post"}, 32'(done), 32'd0);
    chk({name, "_ready_post"}, 32'(ready), 32'd1);
    $display("op %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", name, a, b, ci, sum, c_out);
  endtask

  initial begin
    // Reset with random inputs applied
    rst_n = 1'b0;
    start = 1'($urandom); in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); c_in = 1'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sum",   32'(sum),   32'd0);
    chk("rst_cout",  32'(c_out), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    exp_sum = '0; exp_cout = 1'b0;
    $display("reset released: ready=%0d sum=%02h", ready, sum);

    run_op("basic",   8'h35, 8'h4A, 1'b0, 0);
    chk("basic_exact", {23'd0, c_out, sum}, {23'd0, 1'b0, 8'h7F});
    run_op("ripple1", 8'hFF, 8'h01, 1'b0, 0);
    chk("ripple1_exact", {23'd0, c_out, sum}, {23'd0, 1'b1, 8'h00});
    run_op("ripple2", 8'hFF, 8'hFF, 1'b1, 0);
    chk("ripple2_exact", {23'd0, c_out, sum}, {23'd0, 1'b1, 8'hFF});
    // Stray start during the third SHIFT cycle must be ignored
    run_op("ignored", 8'h10, 8'h20, 1'b0, 2);
    chk("ignored_exact", {23'd0, c_out, sum}, {23'd0, 1'b0, 8'h30});

    // Back-to-back with start held high
    @(negedge clk);
    in_a = 8'h01; in_b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    in_a = 8'h80; in_b = 8'h80;
    for (int k = 1; k <= 2 * WIDTH + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b_done_k%0d", k), 32'(done), 32'(k == WIDTH || k == 2 * WIDTH + 2));
      if (k == WIDTH) begin
        chk("b2b_sum1",  32'(sum),   32'h02);
        chk("b2b_cout1", 32'(c_out), 32'd0);
        $display("b2b first  sum=%02h cout=%0d", sum, c_out);
      end
      if (k == WIDTH + 1) chk("b2b_idle", 32'(ready), 32'd1);
      if (k == WIDTH + 2) begin
        chk("b2b_accept", 32'(busy), 32'd1);
        start = 1'b0;
      end
    end
    chk("b2b_sum2",  32'(sum),   32'h00);
    chk("b2b_cout2", 32'(c_out), 32'd1);
    $display("b2b second sum=%02h cout=%0d", sum, c_out);
    exp_sum = 8'h00; exp_cout = 1'b1;
    @(negedge clk);

    // Reset mid-operation
    in_a = 8'hC3; in_b = 8'h3C; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_sum",   32'(sum),   32'd0);
    chk("midrst_cout",  32'(c_out), 32'd0);
    for (int k = 0; k < WIDTH + 2; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_nodone_%0d", k), 32'(done), 32'd0);
      if (k == 2) rst_n = 1'b1;
    end
    $display("mid-op reset: ready=%0d sum=%02h cout=%0d", ready, sum, c_out);
    exp_sum = '0; exp_cout = 1'b0;
    run_op("postrst", 8'h0F, 8'hF0, 1'b1, 0);
    chk("postrst_exact", {23'd0, c_out, sum}, {23'd0, 1'b1, 8'h00});

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 20; n++) begin
      run_op($sformatf("rand%0d", n), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
             (n % 3 == 0) ? int'($urandom_range(1, WIDTH - 1)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
